// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the memory-access sequencer:
//   state_t        - sequencer states (IDLE, BUS, DONE, ERR)
//   SZ_BYTE/HALF/WORD - encodings of the ByteAccess size field
//   calc_strobe    - byte-lane strobes for a size and byte offset
//   replicate      - lane replication of LSB-justified store data
//   align_offset   - force-aligned byte offset for an access size
//   is_misaligned  - misalignment test for an access size and offset
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 2'b11 falls into the default arms and behaves as a word.
  function automatic logic [3:0] calc_strobe(input logic [1:0] size,
                                             input logic [1:0] off);
    logic [3:0] strb;
    case (size)
      SZ_BYTE: strb = 4'b0001 << off;
      SZ_HALF: strb = 4'b0011 << {off[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Copy the low byte/half into every lane so any offset finds its data.
  function automatic logic [31:0] replicate(input logic [1:0]  size,
                                            input logic [31:0] wd);
    logic [31:0] rep;
    case (size)
      SZ_BYTE: rep = {4{wd[7:0]}};
      SZ_HALF: rep = {2{wd[15:0]}};
      default: rep = wd;
    endcase
    return rep;
  endfunction

  function automatic logic [1:0] align_offset(input logic [1:0] size,
                                              input logic [1:0] off);
    logic [1:0] aoff;
    case (size)
      SZ_BYTE: aoff = off;
      SZ_HALF: aoff = off & 2'b10;
      default: aoff = 2'b00;
    endcase
    return aoff;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend
// Combinational load-result formatter. Moves the addressed byte/half of the
// read word down to bit 0 and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata  in  32 : raw word returned by memory
//   off    in  2  : (aligned) byte offset within the word
//   size   in  2  : access size (SZ_BYTE / SZ_HALF / word)
//   uns    in  1  : 1 = zero-extend, 0 = sign-extend (ignored for words)
//   result out 32 : extended load value
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] shifted;

  // Shift the selected lane down, then keep 8/16/32 bits and extend.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    result  = shifted;
    case (size)
      SZ_BYTE: result = uns ? {24'h0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = uns ? {16'h0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Sequencer between the multicycle controller and a valid/ready memory port.
// Accepts one load/store at a time, drives word-aligned address, strobes and
// lane-replicated data from registers, waits for mem_ready, and returns an
// extended load result with a one-cycle Done pulse.
// Configuration macro: MISALIGN_TRAP_EN
//   defined   - misaligned half/word requests skip the bus and pulse
//               Done together with MisalignErr.
//   undefined - misaligned requests are force-aligned and run normally;
//               MisalignErr is tied 0.
// Ports:
//   CLK, Reset          : clock (rising edge), async active-high reset
//   Req, MemWrite, ByteAccess, Unsigned, Adr, WriteData : request, sampled in IDLE
//   ReadData, Done, Busy, MisalignErr : controller-side results/status
//   mem_valid, mem_ready, mem_we, mem_addr, mem_wstrb, mem_wdata, mem_rdata :
//                         memory bus
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Req,
  input  logic          MemWrite,
  input  logic [1:0]    ByteAccess,
  input  logic          Unsigned,
  input  logic [AW-1:0] Adr,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] ReadData,
  output logic          Done,
  output logic          Busy,
  output logic          MisalignErr,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t      state;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_uns;
  logic [1:0]  eff_off;
  logic [31:0] ext_data;

  // Offset actually used for lanes; misaligned requests that are not
  // trapped get snapped down to the natural boundary of their size.
  always_comb begin
    eff_off = align_offset(ByteAccess, Adr[1:0]);
  end

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .off    (lat_off),
    .size   (lat_size),
    .uns    (lat_uns),
    .result (ext_data)
  );

  // Single FSM; all outputs are registered so the bus sees glitch-free,
  // stable signals for the whole BUS state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      lat_off   <= 2'b00;
      lat_size  <= SZ_BYTE;
      lat_uns   <= 1'b0;
      ReadData  <= '0;
      Done      <= 1'b0;
      Busy      <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= '0;
`ifdef MISALIGN_TRAP_EN
      MisalignErr <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      MisalignErr <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (Req) begin
            lat_off   <= eff_off;
            lat_size  <= ByteAccess;
            lat_uns   <= Unsigned;
            mem_addr  <= {Adr[AW-1:2], 2'b00};
            mem_wstrb <= calc_strobe(ByteAccess, eff_off);
            mem_wdata <= replicate(ByteAccess, WriteData);
            Busy      <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            if (is_misaligned(ByteAccess, Adr[1:0])) begin
              state       <= ST_ERR;
              Done        <= 1'b1;
              MisalignErr <= 1'b1;
            end else begin
`else
            begin
`endif
              state     <= ST_BUS;
              mem_valid <= 1'b1;
              mem_we    <= MemWrite;
            end
          end
        end
        ST_BUS: begin
          if (mem_ready) begin
            if (!mem_we) begin
              ReadData <= ext_data;
            end
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            Done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef MISALIGN_TRAP_EN
  assign MisalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit. Inputs change and
// outputs are sampled 1 time unit after the rising clock edge.
module tb_mem_access_unit;

  logic        CLK;
  logic        Reset;
  logic        Req;
  logic        MemWrite;
  logic [1:0]  ByteAccess;
  logic        Unsigned;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Done;
  logic        Busy;
  logic        MisalignErr;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Req         (Req),
    .MemWrite    (MemWrite),
    .ByteAccess  (ByteAccess),
    .Unsigned    (Unsigned),
    .Adr         (Adr),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Done        (Done),
    .Busy        (Busy),
    .MisalignErr (MisalignErr),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Free-running 10-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request for the current cycle (cycle 0 of an access)
  task automatic applyStimulus(input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] adr,
                               input logic [31:0] wd);
    MemWrite   = we;
    ByteAccess = size;
    Unsigned   = uns;
    Adr        = adr;
    WriteData  = wd;
    Req        = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if (ReadData !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_readdata: got %h expected %h", ReadData, 32'h0);
    end
    checks++;
    if ({Done, Busy, MisalignErr, mem_valid, mem_we} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected %b",
                         {Done, Busy, MisalignErr, mem_valid, mem_we}, 5'b0);
    end
    checks++;
    if ({mem_addr, mem_wstrb, mem_wdata} !== 68'h0) begin
      errors++; $display("[TB] FAIL reset_bus: got %h/%h/%h expected 0", mem_addr, mem_wstrb, mem_wdata);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_word_load();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    tick();
    Req = 1'b0;
    checks++;
    if ({mem_valid, mem_we, Busy, Done} !== 4'b1010) begin
      errors++; $display("[TB] FAIL wl_c1_flags: got %b expected %b", {mem_valid, mem_we, Busy, Done}, 4'b1010);
    end
    checks++;
    if (mem_addr !== 32'h100) begin
      errors++; $display("[TB] FAIL wl_addr: got %h expected %h", mem_addr, 32'h100);
    end
    tick();
    checks++;
    if ({Done, mem_valid} !== 2'b10) begin
      errors++; $display("[TB] FAIL wl_c2_done: got %b expected %b", {Done, mem_valid}, 2'b10);
    end
    checks++;
    if (ReadData !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL wl_data: got %h expected %h", ReadData, 32'hDEADBEEF);
    end
    tick();
    checks++;
    if ({Done, Busy} !== 2'b00) begin
      errors++; $display("[TB] FAIL wl_c3_idle: got %b expected %b", {Done, Busy}, 2'b00);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_byte_load(input logic uns, input logic [31:0] exp);
    int valid_cycles;
    valid_cycles = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h80FF1234;
    applyStimulus(1'b0, 2'b00, uns, 32'h103, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      Req = 1'b0;
      if (mem_valid === 1'b1 && Done === 1'b0) valid_cycles++;
      if (i == 4) mem_ready = 1'b1;
    end
    checks++;
    if (valid_cycles !== 4) begin
      errors++; $display("[TB] FAIL bl_valid_cycles: got %0d expected %0d", valid_cycles, 4);
    end
    checks++;
    if (mem_wstrb !== 4'b1000) begin
      errors++; $display("[TB] FAIL bl_strobe: got %b expected %b", mem_wstrb, 4'b1000);
    end
    tick();
    mem_ready = 1'b0;
    checks++;
    if (Done !== 1'b1) begin
      errors++; $display("[TB] FAIL bl_done: got %b expected %b", Done, 1'b1);
    end
    checks++;
    if (ReadData !== exp) begin
      errors++; $display("[TB] FAIL bl_data_uns%0d: got %h expected %h", uns, ReadData, exp);
    end
    tick();
  endtask

  task automatic test_half_store();
    mem_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD);
    tick();
    Req = 1'b0;
    checks++;
    if (mem_wstrb !== 4'b1100) begin
      errors++; $display("[TB] FAIL hs_strobe: got %b expected %b", mem_wstrb, 4'b1100);
    end
    checks++;
    if (mem_wdata !== 32'hABCDABCD) begin
      errors++; $display("[TB] FAIL hs_wdata: got %h expected %h", mem_wdata, 32'hABCDABCD);
    end
    checks++;
    if (mem_addr !== 32'h20) begin
      errors++; $display("[TB] FAIL hs_addr: got %h expected %h", mem_addr, 32'h20);
    end
    checks++;
    if ({mem_valid, mem_we} !== 2'b11) begin
      errors++; $display("[TB] FAIL hs_we: got %b expected %b", {mem_valid, mem_we}, 2'b11);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (Done !== 1'b1) begin
      errors++; $display("[TB] FAIL hs_done: got %b expected %b", Done, 1'b1);
    end
    checks++;
    if (ReadData !== 32'h00000080) begin
      errors++; $display("[TB] FAIL hs_readdata_held: got %h expected %h", ReadData, 32'h00000080);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    mem_ready = 1'b0;
    mem_rdata = 32'h12345678;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    tick();
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_first_valid: got %b expected %b", mem_valid, 1'b1);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (Done !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_done: got %b expected %b", Done, 1'b1);
    end
    tick();
    checks++;
    if ({mem_valid, Busy, Done} !== 3'b000) begin
      errors++; $display("[TB] FAIL b2b_no_double_accept: got %b expected %b", {mem_valid, Busy, Done}, 3'b000);
    end
    tick();
    Req = 1'b0;
    checks++;
    if ({mem_valid, Busy} !== 2'b11) begin
      errors++; $display("[TB] FAIL b2b_second_valid: got %b expected %b", {mem_valid, Busy}, 2'b11);
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++;
    if ({Done, ReadData} !== {1'b1, 32'h12345678}) begin
      errors++; $display("[TB] FAIL b2b_second_done: got %b/%h expected 1/%h", Done, ReadData, 32'h12345678);
    end
    tick();
  endtask

  task automatic test_misaligned(input string name, input logic [1:0] size,
                                 input logic [31:0] adr, input logic [31:0] rdata,
                                 input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                                 input logic [31:0] exp_data);
    logic [31:0] prev;
    prev = ReadData;
    mem_ready = 1'b1;
    mem_rdata = rdata;
    applyStimulus(1'b0, size, 1'b0, adr, 32'h0);
    tick();
    Req = 1'b0;
`ifdef MISALIGN_TRAP_EN
    checks++;
    if ({Done, MisalignErr, mem_valid} !== 3'b110) begin
      errors++; $display("[TB] FAIL %s_trap: got %b expected %b", name, {Done, MisalignErr, mem_valid}, 3'b110);
    end
    tick();
    checks++;
    if ({Done, MisalignErr, mem_valid, Busy} !== 4'b0000) begin
      errors++; $display("[TB] FAIL %s_trap_end: got %b expected %b", name, {Done, MisalignErr, mem_valid, Busy}, 4'b0000);
    end
    checks++;
    if (ReadData !== prev) begin
      errors++; $display("[TB] FAIL %s_trap_data: got %h expected %h", name, ReadData, prev);
    end
`else
    checks++;
    if ({mem_valid, MisalignErr} !== 2'b10) begin
      errors++; $display("[TB] FAIL %s_valid: got %b expected %b", name, {mem_valid, MisalignErr}, 2'b10);
    end
    checks++;
    if ({mem_addr, mem_wstrb} !== {exp_addr, exp_strb}) begin
      errors++; $display("[TB] FAIL %s_aligned: got %h/%b expected %h/%b", name, mem_addr, mem_wstrb, exp_addr, exp_strb);
    end
    tick();
    checks++;
    if ({Done, MisalignErr, ReadData} !== {1'b1, 1'b0, exp_data}) begin
      errors++; $display("[TB] FAIL %s_done: got %b/%b/%h expected 1/0/%h", name, Done, MisalignErr, ReadData, exp_data);
    end
    tick();
`endif
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_bus();
    mem_ready = 1'b0;
    mem_rdata = 32'hFFFFFFFF;
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    tick();
    Req = 1'b0;
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_bus_valid: got %b expected %b", mem_valid, 1'b1);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({mem_valid, Busy, ReadData} !== 34'h0) begin
      errors++; $display("[TB] FAIL rst_async: got %b/%b/%h expected 0/0/0", mem_valid, Busy, ReadData);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (Done !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_no_done: got %b expected %b", Done, 1'b0);
    end
    Reset = 1'b0;
    mem_rdata = 32'h0BADF00D;
    tick();
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
    tick();
    Req = 1'b0;
    checks++;
    if ({mem_valid, mem_addr} !== {1'b1, 32'h44}) begin
      errors++; $display("[TB] FAIL rst_next_valid: got %b/%h expected 1/%h", mem_valid, mem_addr, 32'h44);
    end
    tick();
    checks++;
    if ({Done, ReadData} !== {1'b1, 32'h0BADF00D}) begin
      errors++; $display("[TB] FAIL rst_next_done: got %b/%h expected 1/%h", Done, ReadData, 32'h0BADF00D);
    end
    mem_ready = 1'b0;
    tick();
  endtask

  initial begin
    Reset      = 1'b1;
    Req        = 1'b0;
    MemWrite   = 1'b0;
    ByteAccess = 2'b00;
    Unsigned   = 1'b0;
    Adr        = 32'h0;
    WriteData  = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    $display("[TB] starting mem_access_unit bench");
    test_reset();
    test_word_load();
    test_byte_load(1'b0, 32'hFFFFFF80);
    test_byte_load(1'b1, 32'h00000080);
    test_half_store();
    test_back_to_back();
    test_misaligned("mis_word", 2'b10, 32'h101, 32'hCAFEF00D, 32'h100, 4'b1111, 32'hCAFEF00D);
    test_misaligned("mis_half", 2'b01, 32'h23, 32'h80010000, 32'h20, 4'b1100, 32'hFFFF8001);
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access sequencer between the multicycle controller/datapath and an external memory port with variable wait states. It accepts one load or store request at a time, generates byte strobes and lane-replicated write data, holds a valid/ready handshake until the memory responds, and returns a lane-aligned, sign- or zero-extended load result with a one-cycle `Done` pulse. The controller FSM stays in its memory state until `Done`.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; only 32 is supported.

Ports:
- `CLK` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Req` in 1: start access; sampled only in IDLE.
- `MemWrite` in 1: 1 = store, 0 = load; sampled with `Req`.
- `ByteAccess` in 2: size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `Unsigned` in 1: load zero-extend (funct3[2]); sampled with `Req`.
- `Adr` in AW: byte address; sampled with `Req`.
- `WriteData` in 32: store data, LSB-justified; sampled with `Req`.
- `ReadData` out 32: extended load result; updated on load completion and held otherwise.
- `Done` out 1: one-cycle completion pulse.
- `Busy` out 1: high in every state except IDLE.
- `MisalignErr` out 1: pulses with `Done` on a trapped misaligned access. Only present when `MISALIGN_TRAP_EN` is defined; otherwise tied 0.
- `mem_valid` out 1: bus request.
- `mem_ready` in 1: bus response and accept.
- `mem_we` out 1: bus write enable.
- `mem_addr` out AW: word-aligned address; [1:0] = 00.
- `mem_wstrb` out 4: byte-lane strobes.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read word, valid when `mem_valid & mem_ready & !mem_we`.

## Operation
- States:
  - IDLE: `Req` latches `MemWrite`, `ByteAccess`, `Unsigned`, `Adr`, `WriteData`, strobes and replicated data into registers.
    - Goes to ERR on a trapped misalignment, else to BUS.
  - BUS: `mem_valid`=1. All bus outputs come from registers and are stable until `mem_ready`.
    - On `mem_ready`: for loads, capture the extended result into `ReadData`; go to DONE.
  - DONE: `Done`=1 for one cycle, then go to IDLE.
  - ERR (macro only): `Done`=1 and `MisalignErr`=1. No bus cycle and `ReadData` unchanged. Then go to IDLE.
- `Req` outside IDLE is ignored. There is no queueing.
- Strobes (off = `Adr[1:0]`):
  - byte: `4'b0001<<off`.
  - half: `4'b0011<<(2*off[1])`.
  - word: `4'b1111`.
  - Load cycles also drive the strobes; memory ignores them.
- Write data:
  - byte: `{4{WriteData[7:0]}}`.
  - half: `{2{WriteData[15:0]}}`.
  - word: unchanged.
- Load extraction: shift `mem_rdata` right by `8*off` and keep 8/16/32 bits per size. Sign-extend unless `Unsigned`, which zero-extends. Word ignores `Unsigned`.
- Misaligned: half with `off[0]`=1; word with `off`≠0.

## Timing
- Reset values: state IDLE. `ReadData`=0; `Done`, `Busy`, `MisalignErr`, `mem_valid`, `mem_we`=0; `mem_addr`, `mem_wstrb`, `mem_wdata`=0.
- `Req` in cycle 0 → `mem_valid` in cycle 1.
- `mem_ready` in cycle k ≥ 1 → `Done` and valid `ReadData` in cycle k+1. The minimum latency is 2 cycles.
- `mem_valid` never deasserts before `mem_ready` except on `Reset`. `mem_ready` while `mem_valid`=0 is ignored.
- `Req` in the same cycle as `Done` is ignored, because the FSM is not yet in IDLE. The earliest next accept is the cycle after `Done`.
- `Reset` mid-BUS drops `mem_valid` asynchronously. The memory must tolerate an abandoned request. No `Done` is produced.
- Trapped misalignment: `Req` in cycle 0 → `Done` and `MisalignErr` in cycle 1.

## Configuration
- `MISALIGN_TRAP_EN` defined: misaligned requests go to ERR and assert `MisalignErr`. No bus transaction occurs.
- `MISALIGN_TRAP_EN` undefined: the ERR state and `MisalignErr` logic are removed and the output is tied 0. Misaligned addresses are force-aligned:
  - half uses `off & 2'b10`.
  - word uses `off = 0`.
  - The access proceeds normally.

## Structure
- `mem_pkg`: state enum (IDLE, BUS, DONE, ERR), size constants (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), strobe/replication function.
- Sub-module `load_extend`: combinational. Takes the read word, offset, size and `Unsigned`, and produces the 32-bit result. It is instantiated once, between `mem_rdata` and the `ReadData` register.

## Test plan
- Word load, zero wait:
  - Stimulus: `Adr`=0x100, `mem_ready` tied 1, `mem_rdata`=0xDEADBEEF.
  - Response: `mem_addr`=0x100 in cycle 1, `Done` in cycle 2, `ReadData`=0xDEADBEEF.
- Signed byte load:
  - Stimulus: `Adr`=0x103, `mem_rdata`=0x80FF_1234, 3 wait cycles.
  - Response: `mem_valid` held for 4 cycles, then `ReadData`=0xFFFF_FF80. With `Unsigned`=1 the response is 0x0000_0080.
- Half store:
  - Stimulus: `Adr`=0x22, `WriteData`=0x0000_ABCD.
  - Response: `mem_wstrb`=4'b1100, `mem_wdata`=0xABCD_ABCD, `mem_addr`=0x20, `mem_we`=1.
- Back-to-back requests:
  - Stimulus: `Req` held high through `Done`.
  - Response: the second access starts `mem_valid` exactly 2 cycles after `Done`. There is no double accept on the `Done` cycle.
- Misaligned word load at 0x101:
  - Macro on: `Done` and `MisalignErr` in cycle 1, no `mem_valid`.
  - Macro off: `mem_addr`=0x100, `mem_wstrb`=4'b1111, normal completion.
- Reset mid-BUS:
  - Stimulus: assert `Reset` while waiting with `mem_ready`=0.
  - Response: `mem_valid`, `Busy`, `ReadData` all 0 immediately, with no `Done`. The next `Req` after release proceeds normally.
